// File: rtl/controlador_display.sv
// controlador_display: scan controller for a 4-digit multiplexed seven-segment display.
// Optional blanking gap between digits is enabled with `define CTRL_DISPLAY_BLANK_EN;
// without it the scan moves straight from one digit to the next.
module controlador_display #(
    parameter int unsigned BLANK_CYC = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_mux,
    input  logic        tick_blink,
    input  logic [15:0] dados,
    input  logic [3:0]  blink_mask,
    output logic [6:0]  seg,
    output logic [3:0]  anodo,
    output logic [1:0]  digito_atual
);

    typedef enum logic [1:0] {ESPERA, ATIVO, APAGADO} state_t;

    if (BLANK_CYC < 1) begin : g_bad_blank
        $error("BLANK_CYC must be at least 1");
    end

    state_t      state, state_d;
    logic        s_mux, s_blink, prev_mux, edge_mux;
    logic [1:0]  dig_d;
    logic [3:0]  val, val_d;
    logic [6:0]  seg_d;
    logic [3:0]  anodo_d;

`ifdef CTRL_DISPLAY_BLANK_EN
    localparam int unsigned CW = $clog2(BLANK_CYC + 1);
    logic [CW-1:0] cnt, cnt_d;
`endif

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    function automatic logic [3:0] pick(input logic [15:0] d, input logic [1:0] i);
        pick = d[{i, 2'b00} +: 4];
    endfunction

    assign edge_mux = s_mux & ~prev_mux;

    // Next state, digit snapshot, and the output values they imply
    always_comb begin
        state_d = state;
        dig_d   = digito_atual;
        val_d   = val;
`ifdef CTRL_DISPLAY_BLANK_EN
        cnt_d   = cnt;
`endif
        case (state)
            ESPERA: begin
                if (edge_mux) begin
                    state_d = ATIVO;
                    dig_d   = 2'd0;
                    val_d   = pick(dados, 2'd0);
                end
            end
            ATIVO: begin
                if (edge_mux) begin
                    dig_d = digito_atual + 2'd1;
`ifdef CTRL_DISPLAY_BLANK_EN
                    state_d = APAGADO;
                    cnt_d   = CW'(BLANK_CYC - 1);
`else
                    val_d = pick(dados, dig_d);
`endif
                end
            end
`ifdef CTRL_DISPLAY_BLANK_EN
            APAGADO: begin
                if (cnt == '0) begin
                    state_d = ATIVO;
                    val_d   = pick(dados, digito_atual);
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
`endif
            default: state_d = ESPERA;
        endcase

        // Outputs are derived from the next state so they register alongside it
        seg_d   = '1;
        anodo_d = '1;
        if (state_d == ATIVO) begin
            seg_d = decode(val_d);
            if (!(blink_mask[dig_d] && !s_blink))
                anodo_d = ~(4'b0001 << dig_d);
        end
    end

    // State, sample registers and registered outputs
    always_ff @(posedge clk) begin
        s_blink <= tick_blink;
        if (reset) begin
            state        <= ESPERA;
            s_mux        <= 1'b1;
            prev_mux     <= 1'b1;
            val          <= '0;
            digito_atual <= '0;
            seg          <= '1;
            anodo        <= '1;
`ifdef CTRL_DISPLAY_BLANK_EN
            cnt          <= '0;
`endif
        end else begin
            state        <= state_d;
            s_mux        <= tick_mux;
            prev_mux     <= s_mux;
            val          <= val_d;
            digito_atual <= dig_d;
            seg          <= seg_d;
            anodo        <= anodo_d;
`ifdef CTRL_DISPLAY_BLANK_EN
            cnt          <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_controlador_display.sv
// Directed testbench for controlador_display (scan, decode, snapshot, blink, reset).
module tb_controlador_display;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick_mux;
    logic        tick_blink;
    logic [15:0] dados;
    logic [3:0]  blink_mask;
    logic [6:0]  seg;
    logic [3:0]  anodo;
    logic [1:0]  digito_atual;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    controlador_display #(.BLANK_CYC(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .tick_mux     (tick_mux),
        .tick_blink   (tick_blink),
        .dados        (dados),
        .blink_mask   (blink_mask),
        .seg          (seg),
        .anodo        (anodo),
        .digito_atual (digito_atual)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  m;
        logic        b;
        logic [6:0]  s;
        logic [3:0]  a;
        logic [1:0]  g;
    } vec_t;

    vec_t tbl [12];

    task automatic step(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle pulse on tick_mux; returns after the resulting transition has registered
    task automatic pulse();
        tick_mux = 1'b1;
        step(1);
        tick_mux = 1'b0;
        step(1);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [6:0] s, input logic [3:0] a,
                           input logic [1:0] g);
        chk({name, ".seg"}, 32'(seg), 32'(s));
        chk({name, ".anodo"}, 32'(anodo), 32'(a));
        chk({name, ".digito"}, 32'(digito_atual), 32'(g));
    endtask

    initial begin
        tbl[0]  = '{16'h4321, 4'h0, 1'b1, 7'b0100100, 4'b1101, 2'd1};
        tbl[1]  = '{16'h4321, 4'h0, 1'b1, 7'b0110000, 4'b1011, 2'd2};
        tbl[2]  = '{16'h4321, 4'h0, 1'b1, 7'b0011001, 4'b0111, 2'd3};
        tbl[3]  = '{16'h4321, 4'h0, 1'b1, 7'b1111001, 4'b1110, 2'd0};
        tbl[4]  = '{16'h9876, 4'h0, 1'b1, 7'b1111000, 4'b1101, 2'd1};
        tbl[5]  = '{16'h9876, 4'h4, 1'b0, 7'b0000000, 4'b1111, 2'd2};
        tbl[6]  = '{16'h9876, 4'h4, 1'b1, 7'b0010000, 4'b0111, 2'd3};
        tbl[7]  = '{16'hABC5, 4'h0, 1'b1, 7'b0010010, 4'b1110, 2'd0};
        tbl[8]  = '{16'hABC5, 4'h0, 1'b1, 7'b0111111, 4'b1101, 2'd1};
        tbl[9]  = '{16'h0F00, 4'h0, 1'b1, 7'b0111111, 4'b1011, 2'd2};
        tbl[10] = '{16'h0F00, 4'h0, 1'b1, 7'b1000000, 4'b0111, 2'd3};
        tbl[11] = '{16'h0006, 4'h0, 1'b1, 7'b0000010, 4'b1110, 2'd0};

        reset      = 1'b1;
        tick_mux   = 1'b1;
        tick_blink = 1'b1;
        dados      = 16'h4321;
        blink_mask = 4'h0;
        step(2);
        chk_out("reset", 7'h7F, 4'hF, 2'd0);

        // Release with tick_mux already high: no edge
        reset = 1'b0;
        step(3);
        chk_out("release_high", 7'h7F, 4'hF, 2'd0);
        tick_mux = 1'b0;
        step(2);
        chk_out("release_low", 7'h7F, 4'hF, 2'd0);

        pulse();
        chk_out("first_digit", 7'b1111001, 4'b1110, 2'd0);

`ifdef CTRL_DISPLAY_BLANK_EN
        begin
            logic [6:0]  exp_s [4];
            logic [3:0]  exp_a [4];
            int unsigned n;
            exp_s = '{7'b0100100, 7'b0110000, 7'b0011001, 7'b1111001};
            exp_a = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
            for (int i = 0; i < 4; i++) begin
                pulse();
                chk_out("blank_entry", 7'h7F, 4'hF, 2'(i + 1));
                n = 0;
                while (anodo == 4'hF && n < 40) begin
                    step(1);
                    n++;
                end
                chk("blank_len", 32'(n), 32'd8);
                chk_out("blank_exit", exp_s[i], exp_a[i], 2'(i + 1));
            end
            // Edge injected inside the gap is dropped
            pulse();
            n = 0;
            step(2);
            n += 2;
            pulse();
            n += 2;
            while (anodo == 4'hF && n < 40) begin
                step(1);
                n++;
            end
            chk("dropped_edge_len", 32'(n), 32'd8);
            chk_out("dropped_edge_out", 7'b0100100, 4'b1101, 2'd1);
        end
`else
        for (int i = 0; i < 12; i++) begin
            dados      = tbl[i].d;
            blink_mask = tbl[i].m;
            tick_blink = tbl[i].b;
            pulse();
            chk_out($sformatf("vec%0d", i), tbl[i].s, tbl[i].a, tbl[i].g);
        end

        // Snapshot: dados change mid-digit leaves seg untouched
        dados = 16'hFFFF;
        step(3);
        chk_out("snapshot_hold", 7'b0000010, 4'b1110, 2'd0);
        pulse();
        chk_out("snapshot_next", 7'b0111111, 4'b1101, 2'd1);

        // Blink latency and live mask
        blink_mask = 4'b0010;
        tick_blink = 1'b0;
        step(1);
        chk("blink_lat1", 32'(anodo), 32'(4'b1101));
        step(1);
        chk_out("blink_off", 7'b0111111, 4'hF, 2'd1);
        tick_blink = 1'b1;
        step(1);
        chk("blink_on_lat1", 32'(anodo), 32'(4'hF));
        step(1);
        chk("blink_on", 32'(anodo), 32'(4'b1101));
        tick_blink = 1'b0;
        step(2);
        chk("blink_off2", 32'(anodo), 32'(4'hF));
        blink_mask = 4'b0000;
        step(1);
        chk("mask_live", 32'(anodo), 32'(4'b1101));
        tick_blink = 1'b1;

        // Direct move between digits, no all-off cycle
        tick_mux = 1'b1;
        step(1);
        chk("direct_before", 32'(anodo), 32'(4'b1101));
        tick_mux = 1'b0;
        step(1);
        chk_out("direct_after", 7'b0111111, 4'b1011, 2'd2);
`endif

        // Edge and reset together mid-scan: reset wins
        tick_mux = 1'b1;
        step(1);
        reset = 1'b1;
        step(1);
        chk_out("reset_wins", 7'h7F, 4'hF, 2'd0);
        reset = 1'b0;
        step(2);
        chk_out("after_reset_idle", 7'h7F, 4'hF, 2'd0);
        tick_mux = 1'b0;
        step(1);
        dados = 16'h0007;
        pulse();
        chk_out("restart", 7'b1111000, 4'b1110, 2'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
